fetch_stage: RTL and testbench

- Instruction fetch stage that produces the 32-bit instruction word and its PC for the decode stage.
- Holds the program counter and issues one-outstanding-request reads to instruction memory.
- Buffers one word when decode stalls.
- Redirects to a branch/jump target and discards any in-flight or buffered wrong-path words.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage. It keeps at most one memory read in flight and has a one-entry skid buffer.
// Redirects discard any wrong-path word, whether it is in flight, in the skid or on the output.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;

    logic [31:0] r_fetch_pc,   w_fetch_pc;
    logic [31:0] r_req_addr,   w_req_addr;
    logic [31:0] r_instr,      w_instr;
    logic [31:0] r_pc,         w_pc;
    logic        r_valid,      w_valid;
    logic [31:0] r_skid_data,  w_skid_data;
    logic [31:0] r_skid_addr,  w_skid_addr;
    logic        r_skid_full,  w_skid_full;

    logic        w_consume;
    logic        w_out_free;
    logic [31:0] w_target;
    logic [31:0] w_req_inc;
    logic [31:0] w_drain_pc;

    assign w_consume  = r_valid & ~stall;
    assign w_out_free = ~r_valid | w_consume;
    assign w_target   = branch_target & ~32'h0000_0003;
    assign w_req_inc  = r_req_addr + 32'd4;
    // Several redirects can arrive while draining. The most recent target is the one to use.
    assign w_drain_pc = branch_taken ? w_target : r_fetch_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_fetch_pc  = r_fetch_pc;
        w_req_addr  = r_req_addr;
        w_instr     = r_instr;
        w_pc        = r_pc;
        w_valid     = r_valid;
        w_skid_data = r_skid_data;
        w_skid_addr = r_skid_addr;
        w_skid_full = r_skid_full;

        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_REQ;
                w_req_addr  = r_fetch_pc;
            end

            S_REQ: begin
                if (branch_taken) begin
                    w_valid     = 1'b0;
                    w_instr     = NOP_INSTR;
                    w_skid_full = 1'b0;
                    w_fetch_pc  = w_target;
                    if (mem_ready) begin
                        w_req_addr = w_target;
                    end else begin
                        // The old request stays outstanding. It must finish before the target is issued.
                        w_state_nxt = S_DRAIN;
                    end
                end else if (mem_ready) begin
                    if (w_out_free) begin
                        w_instr = mem_rdata;
                        w_pc    = r_req_addr;
                        w_valid = 1'b1;
                    end else begin
                        w_skid_data = mem_rdata;
                        w_skid_addr = r_req_addr;
                        w_skid_full = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                    w_fetch_pc = w_req_inc;
                    w_req_addr = w_req_inc;
                end else if (w_consume) begin
                    w_valid = 1'b0;
                    w_instr = NOP_INSTR;
                end
            end

            S_WAIT: begin
                if (branch_taken) begin
                    w_valid     = 1'b0;
                    w_instr     = NOP_INSTR;
                    w_skid_full = 1'b0;
                    w_fetch_pc  = w_target;
                    w_req_addr  = w_target;
                    w_state_nxt = S_REQ;
                end else if (w_consume) begin
                    w_instr     = r_skid_data;
                    w_pc        = r_skid_addr;
                    w_valid     = 1'b1;
                    w_skid_full = 1'b0;
                    w_state_nxt = S_REQ;
                end
            end

            S_DRAIN: begin
                w_fetch_pc = w_drain_pc;
                if (mem_ready) begin
                    w_req_addr  = w_drain_pc;
                    w_state_nxt = S_REQ;
                end
            end

            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_BOOT;
            r_fetch_pc  <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_pc        <= RESET_PC;
            r_valid     <= 1'b0;
            r_skid_data <= NOP_INSTR;
            r_skid_addr <= RESET_PC;
            r_skid_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc;
            r_req_addr  <= w_req_addr;
            r_instr     <= w_instr;
            r_pc        <= w_pc;
            r_valid     <= w_valid;
            r_skid_data <= w_skid_data;
            r_skid_addr <= w_skid_addr;
            r_skid_full <= w_skid_full;
        end
    end

    assign mem_req     = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign mem_addr    = r_req_addr;
    assign instruction = r_instr;
    assign pc          = r_pc;
    assign valid       = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. The memory returns addr|A0000000 after a programmable wait, and a program-order model checks every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] TAG       = 32'hA000_0000;

    logic        clock, reset, stall, branch_taken;
    logic [31:0] branch_target;
    logic        mem_req, mem_ready;
    logic [31:0] mem_addr, mem_rdata;
    logic [31:0] instruction, pc;
    logic        valid;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .instruction(instruction), .pc(pc), .valid(valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Instruction memory. A request is answered once it has waited lat cycles.
    int   lat = 0;
    int   cnt = 0;
    logic force_rdy = 1'b0;

    always @(negedge clock) begin
        mem_ready <= force_rdy || (mem_req && (cnt >= lat));
        mem_rdata <= mem_addr | TAG;
    end

    always @(posedge clock) begin
        if (reset || !mem_req || mem_ready) cnt <= 0;
        else                                cnt <= cnt + 1;
    end

    // Program-order model. The next word decode sees is either the next sequential address or the latest redirect target.
    logic [31:0] exp_pc = RESET_PC;
    logic        flush_q = 1'b0, hold_q = 1'b0, pend_q = 1'b0;
    logic [31:0] pend_addr = '0;

    always @(posedge clock) begin
        if (reset) begin
            exp_pc  <= RESET_PC;
            flush_q <= 1'b0;
            hold_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pend_q    <= mem_req && !mem_ready;
            pend_addr <= mem_addr;
            flush_q   <= branch_taken;
            hold_q    <= !branch_taken && valid && stall;
            if (branch_taken)          exp_pc <= branch_target & ~32'h3;
            else if (valid && !stall)  exp_pc <= exp_pc + 32'd4;
        end
    end

    always @(negedge clock) begin
        #1;
        if (!reset) begin
            if (flush_q) check("m_flush_valid", {31'd0, valid}, 32'd0);
            if (hold_q)  check("m_hold_valid", {31'd0, valid}, 32'd1);
            if (valid) begin
                check("m_pc", pc, exp_pc);
                check("m_instr", instruction, exp_pc | TAG);
            end else begin
                check("m_nop", instruction, NOP_INSTR);
            end
            if (pend_q) begin
                check("m_req_held", {31'd0, mem_req}, 32'd1);
                check("m_addr_stable", mem_addr, pend_addr);
            end
            check("m_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        repeat (3) step();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instruction, NOP_INSTR);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        reset = 1'b0;

        // Zero-wait streaming
        step();
        check("t1_req", {31'd0, mem_req}, 32'd1);
        check("t1_addr", mem_addr, 32'h0);
        check("t1_valid0", {31'd0, valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_valid", {31'd0, valid}, 32'd1);
            check("t1_pc", pc, 32'(i * 4));
            check("t1_instr", instruction, 32'hA000_0000 + 32'(i * 4));
        end

        // Stall with pc=8 on the output, and word 12 goes to the skid
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_hold_pc", pc, 32'h8);
            check("t2_wait_noreq", {31'd0, mem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        check("t2_skid_pc", pc, 32'hC);
        check("t2_skid_instr", instruction, 32'hA000_000C);
        check("t2_addr16", mem_addr, 32'h10);

        // 3-cycle memory with a redirect while the request to 0x10 is outstanding
        lat = 3;
        step();
        check("t3_addr", mem_addr, 32'h10);
        check("t3_valid0", {31'd0, valid}, 32'd0);
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        check("t3_drain_addr", mem_addr, 32'h10);
        check("t3_drain_req", {31'd0, mem_req}, 32'd1);
        step();
        check("t3_drain_addr2", mem_addr, 32'h10);
        step();
        check("t3_drain_valid", {31'd0, valid}, 32'd0);
        step();
        check("t3_target_addr", mem_addr, 32'h100);
        check("t3_dropped", {31'd0, valid}, 32'd0);
        lat = 0;
        step();
        check("t3_pc", pc, 32'h100);
        check("t3_valid", {31'd0, valid}, 32'd1);

        // Redirect while stalled with a full skid
        stall = 1'b1;
        step();
        check("t4_hold", pc, 32'h100);
        check("t4_wait_noreq", {31'd0, mem_req}, 32'd0);
        branch_taken = 1'b1; branch_target = 32'h200;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        check("t4_valid0", {31'd0, valid}, 32'd0);
        check("t4_nop", instruction, 32'h0000_0013);
        check("t4_addr", mem_addr, 32'h200);
        step();
        check("t4_pc", pc, 32'h200);
        check("t4_instr", instruction, 32'hA000_0200);

        // Low target bits are ignored
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        check("t5_addr", mem_addr, 32'h100);
        check("t5_valid0", {31'd0, valid}, 32'd0);
        step();
        check("t5_pc", pc, 32'h100);

        // Reset while draining, then a late ready during BOOT
        lat = 100;
        branch_taken = 1'b1; branch_target = 32'h300;
        step();
        branch_taken = 1'b0;
        check("t6_drain_req", {31'd0, mem_req}, 32'd1);
        check("t6_drain_addr", mem_addr, 32'h104);
        reset = 1'b1;
        step();
        check("t6_boot_req", {31'd0, mem_req}, 32'd0);
        check("t6_boot_valid", {31'd0, valid}, 32'd0);
        reset = 1'b0; force_rdy = 1'b1;
        step();
        force_rdy = 1'b0; lat = 0;
        check("t6_addr", mem_addr, RESET_PC);
        check("t6_req", {31'd0, mem_req}, 32'd1);
        check("t6_valid0", {31'd0, valid}, 32'd0);
        step();
        check("t6_pc", pc, RESET_PC);
        check("t6_valid", {31'd0, valid}, 32'd1);
        step();
        check("t6_pc4", pc, 32'h4);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
